pc_fetch_ras: RTL and testbench
===============================

Name: pc_fetch_ras

Overview:
Parametrised next-generation program-counter unit for the pipelined core's fetch stage. It holds the PC and selects the next fetch address from four sources: sequential, branch/JAL target, JALR result, or a return-address-stack (RAS) prediction. It adds a fetch stall, a configurable reset vector and a circular RAS of configurable depth. Redirects come from decode (return prediction) and execute (resolved branches and jumps).

Parameters:
D_WIDTH, 32, width of PC and all address ports
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
INSTR_BYTES, 4, sequential increment in bytes
RAS_DEPTH, 4, number of RAS entries (power of two, >=2)

Ports:
CLK  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
Stall  in  1  hold PC; hazard unit freezes fetch
PCSrc  in  1  execute: taken branch or JAL, redirect to PCTarget
PCTarget  in  D_WIDTH  branch/JAL target
JumpReg  in  1  execute: JALR resolved, redirect to Result
Result  in  D_WIDTH  JALR target (ALU result)
RetPredict  in  1  decode: instruction is a return, pop RAS and redirect
CallPush  in  1  execute: call retired through execute, push CallLink
CallLink  in  D_WIDTH  return address to push
RasFlush  in  1  clear RAS (pointer and count to 0)
PC  out  D_WIDTH  current fetch address
PCPlus4  out  D_WIDTH  PC + INSTR_BYTES, combinational
RasValid  out  1  RAS count > 0
RasTop  out  D_WIDTH  top-of-stack entry; 0 when empty

Behaviour:
- Reset (async): PC=RESET_VECTOR, RAS pointer=0, count=0, all entries=0. RasValid=0, RasTop=0, PCPlus4=RESET_VECTOR+INSTR_BYTES. Reset asserted mid-operation discards all pending state immediately.
- PCPlus4 = PC + INSTR_BYTES, modulo 2^D_WIDTH. 0xFFFF_FFFC wraps to 0x0000_0000.
- Next-PC priority, highest first: JumpReg -> {Result[D_WIDTH-1:1],1'b0}; PCSrc -> PCTarget; RetPredict with RasValid -> RasTop; Stall -> PC (hold); otherwise PCPlus4.
- Redirects (JumpReg, PCSrc, RetPredict) override Stall. PC updates one cycle after the select, with no added latency.
- RetPredict while RAS is empty: no pop and no redirect; the next PC follows the lower-priority sources.
- RetPredict is ignored (no pop) when JumpReg or PCSrc is set in the same cycle.
- RetPredict is ignored (no pop) when Stall=1 and no execute redirect is active. The decode instruction is held, so the pop must not repeat.
- RAS push (CallPush): entry[ptr]<=CallLink, ptr<=ptr+1 mod RAS_DEPTH, count<=min(count+1,RAS_DEPTH). A push when full overwrites the oldest entry (circular) and count stays at RAS_DEPTH.
- RAS pop (effective RetPredict): ptr<=ptr-1 mod RAS_DEPTH, count<=count-1. RasTop = entry[ptr-1].
- Push and effective pop in the same cycle: entry[ptr-1]<=CallLink, ptr and count unchanged.
- RasFlush: ptr<=0 and count<=0, taking priority over push and pop in the same cycle. Entries are not cleared. RasFlush does not affect PC selection in that cycle.
- CallPush is independent of Stall and redirects; execute has already committed the call.
- No combinational path from any input to PC. PCPlus4, RasValid and RasTop depend on registered state only.

Test Plan:
- Reset release, 3 free cycles -> PC 0x0, 0x4, 0x8, 0xC; PCPlus4=0x10; RasValid=0.
- Stall=1 for 2 cycles at PC=0x8 -> PC holds 0x8. Stall=1 with PCSrc=1, PCTarget=0x100 -> PC=0x100 next cycle.
- JumpReg=1, Result=0x203, together with PCSrc=1, PCTarget=0x400 -> PC=0x202 (JumpReg wins, LSB cleared).
- CallPush CallLink=0x10, 0x20, then RetPredict twice -> PC=0x20 then 0x10, RasValid=0. A third RetPredict -> sequential PC, no pop.
- RAS_DEPTH=4: push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 -> count=4, RasTop=0xE0. Four pops return 0xE0, 0xD0, 0xC0, 0xB0 (0xA0 overwritten).
- Push 0x30 alongside RetPredict with top=0x20 -> PC=0x20, new RasTop=0x30, count unchanged. RasFlush then RetPredict -> no redirect. Assert rst mid-sequence -> PC=RESET_VECTOR in the same cycle.

Source files
------------

// File: rtl/pc_fetch_ras_if.sv
// Fetch-stage control/redirect bundle between hazard/decode/execute and the PC unit.
// master drives the redirect and RAS controls; slave (the PC unit) returns PC and RAS state.
interface pc_fetch_ras_if #(
   parameter int D_WIDTH = 32
);
   logic               Stall;
   logic               PCSrc;
   logic [D_WIDTH-1:0] PCTarget;
   logic               JumpReg;
   logic [D_WIDTH-1:0] Result;
   logic               RetPredict;
   logic               CallPush;
   logic [D_WIDTH-1:0] CallLink;
   logic               RasFlush;
   logic [D_WIDTH-1:0] PC;
   logic [D_WIDTH-1:0] PCPlus4;
   logic               RasValid;
   logic [D_WIDTH-1:0] RasTop;

   modport master (
      output Stall, PCSrc, PCTarget, JumpReg, Result,
             RetPredict, CallPush, CallLink, RasFlush,
      input  PC, PCPlus4, RasValid, RasTop
   );

   modport slave (
      input  Stall, PCSrc, PCTarget, JumpReg, Result,
             RetPredict, CallPush, CallLink, RasFlush,
      output PC, PCPlus4, RasValid, RasTop
   );
endinterface

// File: rtl/pc_fetch_ras.sv
// Fetch PC register with next-PC select (JALR > branch/JAL > RAS return > stall > sequential) and a circular RAS.
// PC updates on the edge after the select; Stall holds PC but any redirect overrides it; outputs are registered-state only.
module pc_fetch_ras #(
   parameter int                 D_WIDTH      = 32,
   parameter logic [D_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                 INSTR_BYTES  = 4,
   parameter int                 RAS_DEPTH    = 4
) (
   input  logic          CLK,
   input  logic          rst,
   pc_fetch_ras_if.slave bus
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic [D_WIDTH-1:0] pc;
   logic [D_WIDTH-1:0] pc_next;
   logic [D_WIDTH-1:0] pc_plus;
   logic [PW-1:0]      ptr;
   logic [PW-1:0]      ptr_dec;
   logic [CW-1:0]      cnt;
   logic [D_WIDTH-1:0] entries [RAS_DEPTH];
   logic               ras_valid;
   logic [D_WIDTH-1:0] ras_top;
   logic               exec_redir;
   logic               ret_redir;
   logic               pop;

   assign pc_plus    = pc + D_WIDTH'(INSTR_BYTES);
   assign ptr_dec    = ptr - PW'(1);
   assign ras_valid  = (cnt != '0);
   assign ras_top    = ras_valid ? entries[ptr_dec] : '0;
   assign exec_redir = bus.JumpReg | bus.PCSrc;
   assign ret_redir  = bus.RetPredict & ras_valid & ~exec_redir;
   // A stalled decode re-presents the same return next cycle, so only pop once it advances.
   assign pop        = ret_redir & ~bus.Stall;

   always_comb begin
      pc_next = pc_plus;
      if (bus.JumpReg)
         pc_next = bus.Result & ~D_WIDTH'(1);
      else if (bus.PCSrc)
         pc_next = bus.PCTarget;
      else if (ret_redir)
         pc_next = ras_top;
      else if (bus.Stall)
         pc_next = pc;
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst)
         pc <= RESET_VECTOR;
      else
         pc <= pc_next;
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         ptr <= '0;
         cnt <= '0;
         for (int i = 0; i < RAS_DEPTH; i++)
            entries[i] <= '0;
      end else if (bus.RasFlush) begin
         ptr <= '0;
         cnt <= '0;
      end else if (bus.CallPush && pop) begin
         // Return consumed the top while a call refills it: replace in place.
         entries[ptr_dec] <= bus.CallLink;
      end else if (bus.CallPush) begin
         entries[ptr] <= bus.CallLink;
         ptr          <= ptr + PW'(1);
         if (cnt != CW'(RAS_DEPTH))
            cnt <= cnt + CW'(1);
      end else if (pop) begin
         ptr <= ptr_dec;
         cnt <= cnt - CW'(1);
      end
   end

   assign bus.PC       = pc;
   assign bus.PCPlus4  = pc_plus;
   assign bus.RasValid = ras_valid;
   assign bus.RasTop   = ras_top;
endmodule

// File: tb/tb_pc_fetch_ras.sv
// Directed vector table plus randomized run against a queue-based stack model of the fetch PC unit.
module tb_pc_fetch_ras;
   localparam int          DW    = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RV    = 32'h0000_0000;

   logic CLK = 1'b0;
   logic rst = 1'b1;
   always #5 CLK = ~CLK;

   pc_fetch_ras_if #(.D_WIDTH(DW)) ifc ();

   pc_fetch_ras #(
      .D_WIDTH(DW), .RESET_VECTOR(RV), .INSTR_BYTES(4), .RAS_DEPTH(DEPTH)
   ) dut (
      .CLK(CLK), .rst(rst), .bus(ifc.slave)
   );

   typedef struct {
      bit          stall;
      bit          pcsrc;
      logic [31:0] tgt;
      bit          jr;
      logic [31:0] res;
      bit          ret;
      bit          push;
      logic [31:0] link;
      bit          flush;
      logic [31:0] exp_pc;
      bit          exp_valid;
      logic [31:0] exp_top;
   } vec_t;

   vec_t vq[$];
   int checks = 0;
   int failures = 0;

   logic [31:0] m_pc;
   logic [31:0] m_ras[$];

   function automatic vec_t mk(bit st, bit ps, logic [31:0] tg, bit j, logic [31:0] rs,
                               bit rt, bit pu, logic [31:0] lk, bit fl,
                               logic [31:0] epc, bit ev, logic [31:0] etop);
      vec_t v;
      v.stall = st; v.pcsrc = ps; v.tgt = tg; v.jr = j; v.res = rs;
      v.ret = rt; v.push = pu; v.link = lk; v.flush = fl;
      v.exp_pc = epc; v.exp_valid = ev; v.exp_top = etop;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(bit st, bit ps, logic [31:0] tg, bit j, logic [31:0] rs,
                        bit rt, bit pu, logic [31:0] lk, bit fl);
      ifc.Stall = st; ifc.PCSrc = ps; ifc.PCTarget = tg; ifc.JumpReg = j; ifc.Result = rs;
      ifc.RetPredict = rt; ifc.CallPush = pu; ifc.CallLink = lk; ifc.RasFlush = fl;
   endtask

   // Reference: stack as a bounded queue, newest at the back, oldest dropped when over depth.
   task automatic model_step(bit st, bit ps, logic [31:0] tg, bit j, logic [31:0] rs,
                             bit rt, bit pu, logic [31:0] lk, bit fl);
      bit          valid;
      logic [31:0] top;
      bit          do_pop;
      valid  = (m_ras.size() > 0);
      top    = valid ? m_ras[m_ras.size()-1] : 32'h0;
      do_pop = rt && valid && !j && !ps && !st;
      if (j)                 m_pc = {rs[31:1], 1'b0};
      else if (ps)           m_pc = tg;
      else if (rt && valid)  m_pc = top;
      else if (!st)          m_pc = m_pc + 32'd4;
      if (fl) m_ras.delete();
      else if (pu && do_pop) m_ras[m_ras.size()-1] = lk;
      else if (pu) begin
         m_ras.push_back(lk);
         if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (do_pop) void'(m_ras.pop_back());
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

      //          st ps tgt           jr res          rt pu link        fl  exp_pc        v  top
      vq.push_back(mk(0,0,0,            0,0,           0,0,0,           0, 32'h4,        0, 0));
      vq.push_back(mk(0,0,0,            0,0,           0,0,0,           0, 32'h8,        0, 0));
      vq.push_back(mk(1,0,0,            0,0,           0,0,0,           0, 32'h8,        0, 0));
      vq.push_back(mk(1,0,0,            0,0,           0,0,0,           0, 32'h8,        0, 0));
      vq.push_back(mk(1,1,32'h100,      0,0,           0,0,0,           0, 32'h100,      0, 0));
      vq.push_back(mk(0,1,32'h400,      1,32'h203,     0,0,0,           0, 32'h202,      0, 0));
      vq.push_back(mk(0,0,0,            0,0,           0,1,32'h10,      0, 32'h206,      1, 32'h10));
      vq.push_back(mk(0,0,0,            0,0,           0,1,32'h20,      0, 32'h20a,      1, 32'h20));
      vq.push_back(mk(0,0,0,            0,0,           1,0,0,           0, 32'h20,       1, 32'h10));
      vq.push_back(mk(0,0,0,            0,0,           1,0,0,           0, 32'h10,       0, 0));
      vq.push_back(mk(0,0,0,            0,0,           1,0,0,           0, 32'h14,       0, 0));
      vq.push_back(mk(0,0,0,            0,0,           0,1,32'hA0,      0, 32'h18,       1, 32'hA0));
      vq.push_back(mk(0,0,0,            0,0,           0,1,32'hB0,      0, 32'h1c,       1, 32'hB0));
      vq.push_back(mk(0,0,0,            0,0,           0,1,32'hC0,      0, 32'h20,       1, 32'hC0));
      vq.push_back(mk(0,0,0,            0,0,           0,1,32'hD0,      0, 32'h24,       1, 32'hD0));
      vq.push_back(mk(0,0,0,            0,0,           0,1,32'hE0,      0, 32'h28,       1, 32'hE0));
      vq.push_back(mk(0,0,0,            0,0,           1,0,0,           0, 32'hE0,       1, 32'hD0));
      vq.push_back(mk(0,0,0,            0,0,           1,0,0,           0, 32'hD0,       1, 32'hC0));
      vq.push_back(mk(0,0,0,            0,0,           1,0,0,           0, 32'hC0,       1, 32'hB0));
      vq.push_back(mk(0,0,0,            0,0,           1,0,0,           0, 32'hB0,       0, 0));
      vq.push_back(mk(0,0,0,            0,0,           0,1,32'h20,      0, 32'hB4,       1, 32'h20));
      vq.push_back(mk(0,0,0,            0,0,           1,1,32'h30,      0, 32'h20,       1, 32'h30));
      vq.push_back(mk(0,0,0,            0,0,           0,0,0,           1, 32'h24,       0, 0));
      vq.push_back(mk(0,0,0,            0,0,           1,0,0,           0, 32'h28,       0, 0));
      vq.push_back(mk(1,0,0,            0,0,           0,1,32'h50,      0, 32'h28,       1, 32'h50));
      vq.push_back(mk(1,0,0,            0,0,           1,0,0,           0, 32'h50,       1, 32'h50));
      vq.push_back(mk(0,0,0,            0,0,           1,0,0,           0, 32'h50,       0, 0));
      vq.push_back(mk(0,1,32'hFFFF_FFFC,0,0,           0,0,0,           0, 32'hFFFF_FFFC,0, 0));
      vq.push_back(mk(0,0,0,            0,0,           0,0,0,           0, 32'h0,        0, 0));

      #12;
      check("reset_pc", ifc.PC, RV);
      check("reset_pcplus4", ifc.PCPlus4, RV + 32'd4);
      check("reset_rasvalid", {31'b0, ifc.RasValid}, 32'h0);
      check("reset_rastop", ifc.RasTop, 32'h0);
      @(negedge CLK);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].stall, vq[i].pcsrc, vq[i].tgt, vq[i].jr, vq[i].res,
               vq[i].ret, vq[i].push, vq[i].link, vq[i].flush);
         @(posedge CLK);
         #1;
         check($sformatf("vec%0d_pc", i), ifc.PC, vq[i].exp_pc);
         check($sformatf("vec%0d_pcplus4", i), ifc.PCPlus4, vq[i].exp_pc + 32'd4);
         check($sformatf("vec%0d_rasvalid", i), {31'b0, ifc.RasValid}, {31'b0, vq[i].exp_valid});
         check($sformatf("vec%0d_rastop", i), ifc.RasTop, vq[i].exp_top);
      end

      // Asynchronous reset in the middle of a cycle with a live stack entry.
      drive(0, 0, 0, 0, 0, 0, 1, 32'h70, 0);
      @(posedge CLK);
      #1;
      check("pre_reset_rastop", ifc.RasTop, 32'h70);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check("midreset_pc", ifc.PC, RV);
      check("midreset_rasvalid", {31'b0, ifc.RasValid}, 32'h0);
      check("midreset_rastop", ifc.RasTop, 32'h0);
      @(negedge CLK);
      rst = 1'b0;
      m_pc = RV;
      m_ras.delete();

      for (int c = 0; c < 600; c++) begin
         bit          st, ps, j, rt, pu, fl;
         logic [31:0] tg, rs, lk, etop;
         st = ($urandom_range(0, 3) == 0);
         ps = ($urandom_range(0, 7) == 0);
         j  = ($urandom_range(0, 15) == 0);
         rt = ($urandom_range(0, 2) == 0);
         pu = ($urandom_range(0, 2) == 0);
         fl = ($urandom_range(0, 31) == 0);
         tg = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
         rs = $urandom;
         lk = $urandom & 32'h0000_FFFC;
         drive(st, ps, tg, j, rs, rt, pu, lk, fl);
         model_step(st, ps, tg, j, rs, rt, pu, lk, fl);
         @(posedge CLK);
         #1;
         etop = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
         check($sformatf("rnd%0d_pc", c), ifc.PC, m_pc);
         check($sformatf("rnd%0d_pcplus4", c), ifc.PCPlus4, m_pc + 32'd4);
         check($sformatf("rnd%0d_rasvalid", c), {31'b0, ifc.RasValid}, {31'b0, m_ras.size() > 0});
         check($sformatf("rnd%0d_rastop", c), ifc.RasTop, etop);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
